// File: rtl/multicycle_alu.sv
// Multicycle ALU: ADD/SUB/OR complete in one cycle; SLL shifts one bit per cycle.
// ready/busy/done are decoded from the FSM state; Result/Zero/Illegal are registered.
module multicycle_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  Funct,
  input  logic [31:0] Src1,
  input  logic [31:0] Src2,
  input  logic [4:0]  Shamt,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] Result,
  output logic        Zero,
  output logic        Illegal
);

  localparam logic [5:0] FN_ADD = 6'b001001;
  localparam logic [5:0] FN_SUB = 6'b001010;
  localparam logic [5:0] FN_SLL = 6'b100001;
  localparam logic [5:0] FN_OR  = 6'b100101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] acc_reg, acc_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic [31:0] result_reg, result_next;
  logic        zero_reg, zero_next;
  logic        illegal_reg, illegal_next;

  logic [31:0] alu_res;
  logic        alu_illegal;
  logic        shift_req;
  logic        accept;
  logic [31:0] acc_shl;

  // Single-cycle datapath operating straight on the inputs at the accept edge.
  always_comb begin
    alu_res     = 32'd0;
    alu_illegal = 1'b0;
    case (Funct)
      FN_ADD:  alu_res = Src1 + Src2;
      FN_SUB:  alu_res = Src1 - Src2;
      FN_OR:   alu_res = Src1 | Src2;
      FN_SLL:  alu_res = Src1;
      default: alu_illegal = 1'b1;
    endcase
  end

  assign shift_req = (Funct == FN_SLL) && (Shamt != 5'd0);
  assign accept    = start && (state_reg != SHIFT);
  assign acc_shl   = {acc_reg[30:0], 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      acc_reg     <= 32'd0;
      cnt_reg     <= 5'd0;
      result_reg  <= 32'd0;
      zero_reg    <= 1'b1;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
      result_reg  <= result_next;
      zero_reg    <= zero_next;
      illegal_reg <= illegal_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    cnt_next     = cnt_reg;
    result_next  = result_reg;
    zero_next    = zero_reg;
    illegal_next = illegal_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (accept) begin
          if (shift_req) begin
            acc_next   = Src1;
            cnt_next   = Shamt;
            state_next = SHIFT;
          end else begin
            result_next  = alu_res;
            zero_next    = (alu_res == 32'd0);
            illegal_next = alu_illegal;
            state_next   = DONE;
          end
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        acc_next = acc_shl;
        cnt_next = cnt_reg - 5'd1;
        // Last shift writes the final value directly, so done follows this edge.
        if (cnt_reg == 5'd1) begin
          result_next  = acc_shl;
          zero_next    = (acc_shl == 32'd0);
          illegal_next = 1'b0;
          state_next   = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ready   = (state_reg != SHIFT);
  assign busy    = (state_reg == SHIFT);
  assign done    = (state_reg == DONE);
  assign Result  = result_reg;
  assign Zero    = zero_reg;
  assign Illegal = illegal_reg;

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: expected completions are queued at issue
// and checked whenever done is observed.
module tb_multicycle_alu;

  localparam logic [5:0] FN_ADD = 6'b001001;
  localparam logic [5:0] FN_SUB = 6'b001010;
  localparam logic [5:0] FN_SLL = 6'b100001;
  localparam logic [5:0] FN_OR  = 6'b100101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  Funct = 6'd0;
  logic [31:0] Src1 = 32'd0;
  logic [31:0] Src2 = 32'd0;
  logic [4:0]  Shamt = 5'd0;
  logic        ready, busy, done, Zero, Illegal;
  logic [31:0] Result;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  multicycle_alu dut (
    .clk(clk), .rst(rst), .start(start), .Funct(Funct), .Src1(Src1),
    .Src2(Src2), .Shamt(Shamt), .ready(ready), .busy(busy), .done(done),
    .Result(Result), .Zero(Zero), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_val({e.name, "_result"}, Result, e.res);
        check_val({e.name, "_zero"}, {31'd0, Zero}, {31'd0, (e.res == 32'd0)});
        check_val({e.name, "_illegal"}, {31'd0, Illegal}, {31'd0, e.ill});
        $display("done %s: Result=%h Zero=%0b Illegal=%0b", e.name, Result, Zero, Illegal);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input string name, input logic [5:0] fn, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] sh,
                      input logic [31:0] res, input logic ill, input logic completes);
    exp_t e;
    Funct = fn; Src1 = a; Src2 = b; Shamt = sh; start = 1'b1;
    if (completes) begin
      e.res = res; e.ill = ill; e.name = name;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Observes n SHIFT cycles while hammering start with different operands.
  task automatic shift_cycles(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      check_val({name, "_busy"}, {31'd0, busy}, 32'd1);
      check_val({name, "_ready"}, {31'd0, ready}, 32'd0);
      Funct = FN_ADD; Src1 = $urandom; Src2 = $urandom; Shamt = 5'($urandom);
      start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name, input logic [31:0] res, input logic ill);
    check_val({name, "_ready"}, {31'd0, ready}, 32'd1);
    check_val({name, "_busy"}, {31'd0, busy}, 32'd0);
    check_val({name, "_done"}, {31'd0, done}, 32'd0);
    check_val({name, "_result"}, Result, res);
    check_val({name, "_zero"}, {31'd0, Zero}, {31'd0, (res == 32'd0)});
    check_val({name, "_illegal"}, {31'd0, Illegal}, {31'd0, ill});
  endtask

  initial begin
    logic [31:0] a, b, r;
    logic [5:0]  fn;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("reset", 32'd0, 1'b0);

    send("add_wrap", FN_ADD, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 1'b0, 1'b1);
    check_val("add_wrap_latency", {31'd0, done}, 32'd1);
    @(negedge clk);
    check_idle_outputs("idle_hold", 32'd0, 1'b0);

    send("sub_wrap", FN_SUB, 32'd3, 32'd5, 5'd0, 32'hFFFF_FFFE, 1'b0, 1'b1);
    check_val("sub_done", {31'd0, done}, 32'd1);
    send("or_b2b", FN_OR, 32'hF0F0_0000, 32'h0000_F0F0, 5'd0, 32'hF0F0_F0F0, 1'b0, 1'b1);
    check_val("or_b2b_done", {31'd0, done}, 32'd1);
    @(negedge clk);

    send("sll31", FN_SLL, 32'd1, 32'hDEAD_BEEF, 5'd31, 32'h8000_0000, 1'b0, 1'b1);
    shift_cycles("sll31", 31);
    check_val("sll31_done", {31'd0, done}, 32'd1);
    @(negedge clk);

    send("sll0", FN_SLL, 32'h1234_5678, 32'd0, 5'd0, 32'h1234_5678, 1'b0, 1'b1);
    check_val("sll0_done", {31'd0, done}, 32'd1);
    send("sll4", FN_SLL, 32'h8000_000F, 32'd0, 5'd4, 32'h0000_00F0, 1'b0, 1'b1);
    shift_cycles("sll4", 4);
    check_val("sll4_done", {31'd0, done}, 32'd1);
    @(negedge clk);

    send("illegal", 6'b000000, 32'h5555_5555, 32'h1, 5'd0, 32'd0, 1'b1, 1'b1);
    check_val("illegal_done", {31'd0, done}, 32'd1);
    send("add_after_ill", FN_ADD, 32'd2, 32'd2, 5'd0, 32'd4, 1'b0, 1'b1);
    @(negedge clk);

    // SLL abandoned by reset: no completion is queued for it.
    send("sll_rst", FN_SLL, 32'h0000_0003, 32'd0, 5'd10, 32'd0, 1'b0, 1'b0);
    shift_cycles("sll_rst", 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("after_rst", 32'd0, 1'b0);
    @(negedge clk);
    check_val("after_rst_no_done", {31'd0, done}, 32'd0);
    send("add_after_rst", FN_ADD, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0, 1'b1);

    // Back-to-back random single-cycle ops against a reference model.
    for (int i = 0; i < 12; i++) begin
      a = $urandom; b = $urandom;
      case (i % 3)
        0: begin fn = FN_ADD; r = a + b; end
        1: begin fn = FN_SUB; r = a - b; end
        default: begin fn = FN_OR; r = a | b; end
      endcase
      send($sformatf("rand%0d", i), fn, a, b, 5'($urandom), r, 1'b0, 1'b1);
    end
    @(negedge clk);
    @(negedge clk);

    check_val("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
